// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares one register-file write port between two requesters. Each
//   requester feeds a DEPTH-entry FIFO; a round-robin arbiter drains the
//   FIFO heads onto a registered write port. A combinational lookup reports
//   whether a register still has a write buffered or on the port.
//
// Ports
//   clock, reset              clock (rising edge), async active-high reset
//   reqN_valid/addr/data      write request from requester N (N = 0, 1)
//   reqN_ready                FIFO N can accept (registered state only)
//   wr_enable/addr/data       register-file write port (registered)
//   lookup_addr, lookup_hit   RAW hazard query: a pending write targets it

// Per-requester circular FIFO with occupancy counter and address match.
module regfile_write_arbiter_fifo #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_ready,
  output logic              o_nempty,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_hit
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                r_cnt;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [DEPTH-1:0]             w_slot_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so natural PW-bit overflow is the wrap
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: slot validity comes from the pointers/count.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_addr;
      r_data[r_wr_ptr] <= i_data;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off         = PW'(i) - r_rd_ptr;
    assign w_slot_hit[i] = ({1'b0, w_off} < r_cnt) && (r_addr[i] == i_lookup_addr);
  end

  assign o_ready     = (r_cnt != CW'(DEPTH));
  assign o_nempty    = (r_cnt != '0);
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_hit       = |w_slot_hit;
endmodule

module regfile_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit
);
  localparam int NREQ = 2;

  logic [NREQ-1:0]             w_in_vld, w_fifo_rdy, w_rdy, w_push, w_pop;
  logic [NREQ-1:0]             w_nempty, w_fifo_hit;
  logic [NREQ-1:0][ADDR_W-1:0] w_in_addr, w_head_addr;
  logic [NREQ-1:0][DATA_W-1:0] w_in_data, w_head_data;
  logic                        w_gnt_vld, w_gnt_idx;

  logic                        r_last;
  logic                        r_wr_en;
  logic [ADDR_W-1:0]           r_wr_addr;
  logic [DATA_W-1:0]           r_wr_data;

  assign w_in_vld  = {req1_valid, req0_valid};
  assign w_in_addr = {req1_addr,  req0_addr};
  assign w_in_data = {req1_data,  req0_data};

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    regfile_write_arbiter_fifo #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) u_fifo (
      .clock         (clock),
      .reset         (reset),
      .i_push        (w_push[g]),
      .i_addr        (w_in_addr[g]),
      .i_data        (w_in_data[g]),
      .i_pop         (w_pop[g]),
      .i_lookup_addr (lookup_addr),
      .o_ready       (w_fifo_rdy[g]),
      .o_nempty      (w_nempty[g]),
      .o_head_addr   (w_head_addr[g]),
      .o_head_data   (w_head_data[g]),
      .o_hit         (w_fifo_hit[g])
    );
    // Ready is forced low while reset is held, so nothing is accepted then.
    assign w_rdy[g]  = w_fifo_rdy[g] & ~reset;
    assign w_push[g] = w_in_vld[g] & w_rdy[g];
    assign w_pop[g]  = w_gnt_vld & (w_gnt_idx == 1'(g));
  end

  // Round-robin: on contention the requester that did not win last goes.
  assign w_gnt_vld = |w_nempty;
  assign w_gnt_idx = (&w_nempty) ? ~r_last : w_nempty[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_last    <= w_gnt_idx;
        r_wr_addr <= w_head_addr[w_gnt_idx];
        r_wr_data <= w_head_data[w_gnt_idx];
      end
    end
  end

  assign req0_ready = w_rdy[0];
  assign req1_ready = w_rdy[1];
  assign wr_enable  = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign lookup_hit = ~reset & ((|w_fifo_hit) | (r_wr_en & (r_wr_addr == lookup_addr)));
endmodule
